// File: rtl/sc_rand_arbiter_pkg.sv
// Shared definitions for the random-number arbiter slice.
// Holds the FSM encoding, the default seed and the generator feedback taps.
package sc_rand_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_DELIVER = 2'd2
    } arbState_t;

    localparam logic [7:0] DEFAULT_SEED = 8'h99;

    // Feedback taps of the left-shifting generator (new LSB = xor of these bits)
    localparam int unsigned TAP_A = 6;
    localparam int unsigned TAP_B = 5;
    localparam int unsigned TAP_C = 3;
    localparam int unsigned TAP_D = 0;

    function automatic int unsigned ptrWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sc_rand_lfsr.sv
// Left-shifting random generator shared by the arbiter requesters.
// Load wins over stepping; an all-zero register self-recovers to SEED.
module sc_rand_lfsr
    import sc_rand_arbiter_pkg::*;
#(
    parameter int unsigned               RAND_DATAWIDTH = 8,
    parameter logic [RAND_DATAWIDTH-1:0] SEED           = RAND_DATAWIDTH'(DEFAULT_SEED)
) (
    input  logic                      SC_RANDLFSR_CLOCK_50,
    input  logic                      SC_RANDLFSR_RESET_InLow,
    input  logic                      SC_RANDLFSR_stepEn_In,
    input  logic                      SC_RANDLFSR_load_In,
    input  logic [RAND_DATAWIDTH-1:0] SC_RANDLFSR_loadValue_InBUS,
    output logic [RAND_DATAWIDTH-1:0] SC_RANDLFSR_data_OutBUS
);

    logic [RAND_DATAWIDTH-1:0] lfsrReg;
    logic [RAND_DATAWIDTH-1:0] lfsrNext;
    logic                      feedback;

    assign feedback = lfsrReg[TAP_A] ^ lfsrReg[TAP_B] ^ lfsrReg[TAP_C] ^ lfsrReg[TAP_D];

    // Next-value selection: load, zero recovery, shift, or hold
    always_comb begin
        lfsrNext = lfsrReg;
        if (SC_RANDLFSR_load_In) begin
            lfsrNext = SC_RANDLFSR_loadValue_InBUS;
        end else if (lfsrReg == '0) begin
            lfsrNext = SEED;
        end else if (SC_RANDLFSR_stepEn_In) begin
            lfsrNext = {lfsrReg[RAND_DATAWIDTH-2:0], feedback};
        end
    end

    always_ff @(posedge SC_RANDLFSR_CLOCK_50 or negedge SC_RANDLFSR_RESET_InLow) begin
        if (!SC_RANDLFSR_RESET_InLow) begin
            lfsrReg <= SEED;
        end else begin
            lfsrReg <= lfsrNext;
        end
    end

    assign SC_RANDLFSR_data_OutBUS = lfsrReg;

endmodule

// File: rtl/sc_rand_arbiter.sv
// Round-robin arbiter handing one shared random generator to NREQ requesters.
// Each grant runs STEPS generator shifts, then pulses valid for the winner.
module sc_rand_arbiter
    import sc_rand_arbiter_pkg::*;
#(
    parameter int unsigned               NREQ           = 4,
    parameter int unsigned               RAND_DATAWIDTH = 8,
    parameter int unsigned               STEPS          = 8,
    parameter logic [RAND_DATAWIDTH-1:0] SEED           = RAND_DATAWIDTH'(DEFAULT_SEED)
) (
    input  logic                      SC_RANDARB_CLOCK_50,
    input  logic                      SC_RANDARB_RESET_InLow,
    input  logic [NREQ-1:0]           SC_RANDARB_req_InBUS,
    input  logic                      SC_RANDARB_seedload_In,
    input  logic [RAND_DATAWIDTH-1:0] SC_RANDARB_seed_InBUS,
    output logic [NREQ-1:0]           SC_RANDARB_gnt_OutBUS,
    output logic [RAND_DATAWIDTH-1:0] SC_RANDARB_data_OutBUS,
    output logic                      SC_RANDARB_valid_Out,
    output logic                      SC_RANDARB_busy_Out
);

    localparam int unsigned PTR_W = ptrWidth(NREQ);
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    arbState_t             state, stateNext;
    logic [CNT_W-1:0]      stepCnt, stepCntNext;
    logic [PTR_W-1:0]      rrPtr, rrPtrNext;
    logic [PTR_W-1:0]      winIdx, winIdxNext;
    logic [NREQ-1:0]       gntNext;
    logic                  validNext;
    logic                  busyNext;

    logic                  pickFound;
    logic [PTR_W-1:0]      pickIdx;
    int unsigned           cand;

    logic                      lfsrStep;
    logic                      lfsrLoad;
    logic [RAND_DATAWIDTH-1:0] lfsrLoadValue;

    // A zero seed would lock the generator, so it is replaced by SEED
    assign lfsrLoadValue = (SC_RANDARB_seed_InBUS == '0) ? SEED : SC_RANDARB_seed_InBUS;

    // Round-robin search starting at rrPtr, wrapping around
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rrPtr) + i) % NREQ;
            if (!pickFound && SC_RANDARB_req_InBUS[PTR_W'(cand)]) begin
                pickFound = 1'b1;
                pickIdx   = PTR_W'(cand);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext   = state;
        stepCntNext = stepCnt;
        rrPtrNext   = rrPtr;
        winIdxNext  = winIdx;
        gntNext     = SC_RANDARB_gnt_OutBUS;
        validNext   = 1'b0;
        lfsrStep    = 1'b0;
        lfsrLoad    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (SC_RANDARB_seedload_In) begin
                    lfsrLoad = 1'b1;
                end else if (pickFound) begin
                    gntNext     = NREQ'(1) << pickIdx;
                    winIdxNext  = pickIdx;
                    stepCntNext = '0;
                    stateNext   = ST_STEP;
                end
            end
            ST_STEP: begin
                if (stepCnt == CNT_W'(STEPS)) begin
                    validNext = 1'b1;
                    stateNext = ST_DELIVER;
                end else begin
                    lfsrStep    = 1'b1;
                    stepCntNext = stepCnt + CNT_W'(1);
                end
            end
            ST_DELIVER: begin
                gntNext   = '0;
                rrPtrNext = (winIdx == PTR_W'(NREQ - 1)) ? '0 : winIdx + PTR_W'(1);
                stateNext = ST_IDLE;
            end
            default: begin
                gntNext   = '0;
                stateNext = ST_IDLE;
            end
        endcase

        busyNext = (stateNext != ST_IDLE);
    end

    always_ff @(posedge SC_RANDARB_CLOCK_50 or negedge SC_RANDARB_RESET_InLow) begin
        if (!SC_RANDARB_RESET_InLow) begin
            state                 <= ST_IDLE;
            stepCnt               <= '0;
            rrPtr                 <= '0;
            winIdx                <= '0;
            SC_RANDARB_gnt_OutBUS <= '0;
            SC_RANDARB_valid_Out  <= 1'b0;
            SC_RANDARB_busy_Out   <= 1'b0;
        end else begin
            state                 <= stateNext;
            stepCnt               <= stepCntNext;
            rrPtr                 <= rrPtrNext;
            winIdx                <= winIdxNext;
            SC_RANDARB_gnt_OutBUS <= gntNext;
            SC_RANDARB_valid_Out  <= validNext;
            SC_RANDARB_busy_Out   <= busyNext;
        end
    end

    sc_rand_lfsr #(
        .RAND_DATAWIDTH (RAND_DATAWIDTH),
        .SEED           (SEED)
    ) u_lfsr (
        .SC_RANDLFSR_CLOCK_50        (SC_RANDARB_CLOCK_50),
        .SC_RANDLFSR_RESET_InLow     (SC_RANDARB_RESET_InLow),
        .SC_RANDLFSR_stepEn_In       (lfsrStep),
        .SC_RANDLFSR_load_In         (lfsrLoad),
        .SC_RANDLFSR_loadValue_InBUS (lfsrLoadValue),
        .SC_RANDLFSR_data_OutBUS     (SC_RANDARB_data_OutBUS)
    );

endmodule

// File: tb/tb_sc_rand_arbiter.sv
// Self-checking bench for sc_rand_arbiter: idle/seed table, hand-written
// transaction sequences and randomized traffic against a transaction-level model.
module tb_sc_rand_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned STEPS = 8;
    localparam logic [7:0]  SEED  = 8'h99;

    logic            clk;
    logic            rstN;
    logic [NREQ-1:0] req;
    logic            seedLoad;
    logic [W-1:0]    seed;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    data;
    logic            valid;
    logic            busy;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] mData;
    int         mPtr;

    typedef struct {
        logic       seedLoad;
        logic [7:0] seed;
        logic [3:0] req;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[7];

    sc_rand_arbiter #(
        .NREQ           (NREQ),
        .RAND_DATAWIDTH (W),
        .STEPS          (STEPS),
        .SEED           (SEED)
    ) dut (
        .SC_RANDARB_CLOCK_50    (clk),
        .SC_RANDARB_RESET_InLow (rstN),
        .SC_RANDARB_req_InBUS   (req),
        .SC_RANDARB_seedload_In (seedLoad),
        .SC_RANDARB_seed_InBUS  (seed),
        .SC_RANDARB_gnt_OutBUS  (gnt),
        .SC_RANDARB_data_OutBUS (data),
        .SC_RANDARB_valid_Out   (valid),
        .SC_RANDARB_busy_Out    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generator value one cycle later, from the shift and zero-recovery rules
    function automatic logic [7:0] nxt(input logic [7:0] y, input logic stepping);
        if (y == 8'h00) return SEED;
        if (stepping) return {y[6:0], y[6] ^ y[5] ^ y[3] ^ y[0]};
        return y;
    endfunction

    function automatic int pickWinner(input logic [3:0] r, input int p);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && r[2'((p + i) % 4)]) w = (p + i) % 4;
        end
        return w;
    endfunction

    task automatic checkIdle(input string name);
        chk({name, ".gnt"},   32'(gnt),   32'h0);
        chk({name, ".busy"},  32'(busy),  32'h0);
        chk({name, ".valid"}, 32'(valid), 32'h0);
        chk({name, ".data"},  32'(data),  32'(mData));
    endtask

    // One full grant..deliver..idle transaction with per-cycle checks
    task automatic runTxn(input string name, input logic [3:0] reqv, input logic seedMid,
                          input logic dropReq, input logic [3:0] expGnt);
        req      = reqv;
        seedLoad = 1'b0;
        tick();
        mData = nxt(mData, 1'b0);
        chk({name, ".grant"}, 32'(gnt),   32'(expGnt));
        chk({name, ".busy"},  32'(busy),  32'h1);
        chk({name, ".valid"}, 32'(valid), 32'h0);
        chk({name, ".data0"}, 32'(data),  32'(mData));
        if (dropReq) req = '0;
        for (int c = 1; c <= int'(STEPS); c++) begin
            if (seedMid && c == 3) begin
                seedLoad = 1'b1;
                seed     = 8'h5A;
            end else begin
                seedLoad = 1'b0;
            end
            tick();
            mData = nxt(mData, 1'b1);
            chk({name, ".stepData"},  32'(data),  32'(mData));
            chk({name, ".stepValid"}, 32'(valid), 32'h0);
            chk({name, ".stepGnt"},   32'(gnt),   32'(expGnt));
        end
        seedLoad = 1'b0;
        tick();
        mData = nxt(mData, 1'b0);
        chk({name, ".valid"},   32'(valid), 32'h1);
        chk({name, ".dlvGnt"},  32'(gnt),   32'(expGnt));
        chk({name, ".dlvData"}, 32'(data),  32'(mData));
        chk({name, ".dlvBusy"}, 32'(busy),  32'h1);
        tick();
        mData = nxt(mData, 1'b0);
        checkIdle({name, ".after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [7:0] sd;
        int         w;

        vecs[0] = '{1'b1, 8'h00, 4'b0000, 8'h99};
        vecs[1] = '{1'b1, 8'h5A, 4'b0000, 8'h5A};
        vecs[2] = '{1'b0, 8'h00, 4'b0000, 8'h5A};
        vecs[3] = '{1'b1, 8'h01, 4'b1111, 8'h01};
        vecs[4] = '{1'b0, 8'h33, 4'b0000, 8'h01};
        vecs[5] = '{1'b1, 8'hFF, 4'b0110, 8'hFF};
        vecs[6] = '{1'b1, 8'h00, 4'b1111, 8'h99};

        rstN     = 1'b1;
        req      = '0;
        seedLoad = 1'b0;
        seed     = '0;
        mData    = SEED;
        mPtr     = 0;

        // Asynchronous reset takes effect before any clock edge
        #1 rstN = 1'b0;
        #1;
        checkIdle("reset");
        tick();
        tick();
        rstN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkIdle("idleAfterReset");
        end

        // IDLE seed-load table; requests present with a strobe are not arbitrated
        for (int i = 0; i < 7; i++) begin
            seedLoad = vecs[i].seedLoad;
            seed     = vecs[i].seed;
            req      = vecs[i].req;
            tick();
            mData = vecs[i].expData;
            checkIdle($sformatf("seedVec%0d", i));
        end
        seedLoad = 1'b0;
        req      = '0;

        // All requesters held: strict rotation starting at requester 0
        runTxn("rr0", 4'b1111, 1'b0, 1'b0, 4'b0001);
        runTxn("rr1", 4'b1111, 1'b0, 1'b0, 4'b0010);
        runTxn("rr2", 4'b1111, 1'b0, 1'b0, 4'b0100);
        runTxn("rr3", 4'b1111, 1'b0, 1'b0, 4'b1000);
        runTxn("rr4", 4'b1111, 1'b0, 1'b0, 4'b0001);
        mPtr = 1;

        seedLoad = 1'b1;
        seed     = 8'h00;
        req      = '0;
        tick();
        seedLoad = 1'b0;
        mData    = SEED;
        checkIdle("reseed99");

        runTxn("single2", 4'b0100, 1'b0, 1'b0, 4'b0100);
        runTxn("dropReq", 4'b0010, 1'b0, 1'b1, 4'b0010);
        runTxn("seedInStep", 4'b1000, 1'b1, 1'b0, 4'b1000);
        runTxn("b2b0", 4'b0011, 1'b0, 1'b0, 4'b0001);
        runTxn("b2b1", 4'b0011, 1'b0, 1'b0, 4'b0010);
        runTxn("b2b2", 4'b0011, 1'b0, 1'b0, 4'b0001);
        mPtr = 1;

        // Reset three cycles into STEP aborts the transaction
        req = 4'b0001;
        tick();
        chk("abort.grant", 32'(gnt), 32'h1);
        tick();
        tick();
        tick();
        rstN = 1'b0;
        #1;
        mData = SEED;
        checkIdle("abort.reset");
        req = '0;
        tick();
        tick();
        rstN = 1'b1;
        mPtr = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checkIdle("abort.noValid");
        end

        // Seed strobe and request in the same IDLE cycle
        seedLoad = 1'b1;
        seed     = 8'h3C;
        req      = 4'b0001;
        tick();
        seedLoad = 1'b0;
        mData    = 8'h3C;
        checkIdle("seedAndReq");
        runTxn("seedAndReqTxn", 4'b0001, 1'b0, 1'b0, 4'b0001);
        mPtr = 1;

        // Randomized traffic against the transaction-level model
        for (int it = 0; it < 40; it++) begin
            r  = 4'($urandom_range(0, 15));
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                seedLoad = 1'b1;
                seed     = sd;
                req      = r;
                tick();
                seedLoad = 1'b0;
                mData    = (sd == 8'h00) ? SEED : sd;
                checkIdle("rndSeed");
            end else if (r == 4'b0000) begin
                req = '0;
                tick();
                mData = nxt(mData, 1'b0);
                checkIdle("rndIdle");
            end else begin
                w = pickWinner(r, mPtr);
                runTxn("rndTxn", r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'(4'b0001 << w));
                mPtr = (w + 1) % 4;
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
